// File: rtl/instr_encoder_loader_if.sv
// Field-bundle handshake, session control and IMEM write bus of the instruction loader.
// The master drives the bundle and session pulses; the slave encodes bundles and writes IMEM.
interface instr_encoder_loader_if #(
  parameter int unsigned DEPTH_LOG2 = 8
);
  logic                  i_start;
  logic                  i_stop;
  logic                  i_in_valid;
  logic                  o_in_ready;
  logic [1:0]            i_fmt;
  logic [6:0]            i_opcode;
  logic [2:0]            i_funct3;
  logic [6:0]            i_funct7;
  logic [4:0]            i_rd;
  logic [4:0]            i_rs1;
  logic [4:0]            i_rs2;
  logic [12:0]           i_imm;
  logic                  o_mem_we;
  logic [31:0]           o_mem_addr;
  logic [31:0]           o_mem_wdata;
  logic [DEPTH_LOG2:0]   o_count;
  logic                  o_full;
  logic                  o_err;
  logic                  o_busy;

  modport master (
    output i_start, i_stop, i_in_valid, i_fmt, i_opcode, i_funct3, i_funct7,
           i_rd, i_rs1, i_rs2, i_imm,
    input  o_in_ready, o_mem_we, o_mem_addr, o_mem_wdata, o_count, o_full, o_err, o_busy
  );

  modport slave (
    input  i_start, i_stop, i_in_valid, i_fmt, i_opcode, i_funct3, i_funct7,
           i_rd, i_rs1, i_rs2, i_imm,
    output o_in_ready, o_mem_we, o_mem_addr, o_mem_wdata, o_count, o_full, o_err, o_busy
  );
endinterface

// File: rtl/instr_encoder_loader.sv
// Program loader: checks RISC-V field bundles, encodes them as RV32I R/I/S/B words and
// writes them sequentially into IMEM through a two-stage capture/encode pipeline.
module instr_encoder_loader #(
  parameter int unsigned DEPTH_LOG2 = 8,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
  input logic                   i_clk,
  input logic                   i_rst_n,
  instr_encoder_loader_if.slave bus
);

  localparam int unsigned CW  = DEPTH_LOG2 + 1;
  localparam int unsigned Cap = 1 << DEPTH_LOG2;
  localparam logic [CW-1:0] CapVal = CW'(Cap);

  localparam logic [6:0] OpR     = 7'b0110011;
  localparam logic [6:0] OpLoad  = 7'b0000011;
  localparam logic [6:0] OpImm   = 7'b0010011;
  localparam logic [6:0] OpStore = 7'b0100011;
  localparam logic [6:0] OpBr    = 7'b1100011;

  typedef enum logic [1:0] {StIdle, StLoad, StDrain, StFull} state_e;

  state_e r_state, w_state_d;

  logic        r_s1_valid, r_s1_legal;
  logic [1:0]  r_s1_fmt;
  logic [6:0]  r_s1_opcode;
  logic [2:0]  r_s1_funct3;
  logic [6:0]  r_s1_funct7;
  logic [4:0]  r_s1_rd, r_s1_rs1, r_s1_rs2;
  logic [12:0] r_s1_imm;

  logic          r_s2_valid;
  logic [31:0]   r_wdata;
  logic [31:0]   r_addr;
  logic [CW-1:0] r_count, w_count_d;
  logic          r_err;

  logic          w_in_ready, w_accept, w_legal, w_s2_load;
  logic [31:0]   w_enc, w_idx, w_addr_next;
  logic [CW:0]   w_pending;

  assign w_accept  = bus.i_in_valid & w_in_ready;
  assign w_s2_load = r_s1_valid & r_s1_legal & ~bus.i_start;

  // Words already committed to the pipeline count against capacity so it never overfills.
  assign w_pending = {1'b0, r_count} + (CW+1)'(r_s1_valid & r_s1_legal) + (CW+1)'(r_s2_valid);

  // The word leaving stage 2 this cycle is not yet reflected in r_count.
  assign w_idx       = 32'(r_count) + 32'(r_s2_valid);
  assign w_addr_next = BASE_ADDR + (w_idx << 2);

  always_comb begin
    w_legal = 1'b0;
    case (bus.i_fmt)
      2'b00:   w_legal = (bus.i_opcode == OpR);
      2'b01:   w_legal = (bus.i_opcode == OpLoad) || (bus.i_opcode == OpImm);
      2'b10:   w_legal = (bus.i_opcode == OpStore);
      default: w_legal = (bus.i_opcode == OpBr) && !bus.i_imm[0];
    endcase
  end

  always_comb begin
    w_enc = 32'h0;
    case (r_s1_fmt)
      2'b00:   w_enc = {r_s1_funct7, r_s1_rs2, r_s1_rs1, r_s1_funct3, r_s1_rd, r_s1_opcode};
      2'b01:   w_enc = {r_s1_imm[11:0], r_s1_rs1, r_s1_funct3, r_s1_rd, r_s1_opcode};
      2'b10:   w_enc = {r_s1_imm[11:5], r_s1_rs2, r_s1_rs1, r_s1_funct3, r_s1_imm[4:0],
                        r_s1_opcode};
      default: w_enc = {r_s1_imm[12], r_s1_imm[10:5], r_s1_rs2, r_s1_rs1, r_s1_funct3,
                        r_s1_imm[4:1], r_s1_imm[11], r_s1_opcode};
    endcase
  end

  always_comb begin
    w_count_d = r_count;
    if (bus.i_start) begin
      w_count_d = '0;
    end else if (r_s2_valid && (r_count != CapVal)) begin
      w_count_d = r_count + 1'b1;
    end
  end

  always_comb begin
    w_state_d  = r_state;
    w_in_ready = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (bus.i_start) w_state_d = StLoad;
      end
      StLoad: begin
        w_in_ready = (w_pending < (CW+1)'(Cap));
        if (bus.i_start)               w_state_d = StLoad;
        else if (bus.i_stop)           w_state_d = StDrain;
        else if (w_count_d == CapVal)  w_state_d = StFull;
      end
      StDrain: begin
        if (bus.i_start)                     w_state_d = StLoad;
        else if (!r_s1_valid && !r_s2_valid) w_state_d = StIdle;
      end
      StFull: begin
        if (bus.i_start)     w_state_d = StLoad;
        else if (bus.i_stop) w_state_d = StIdle;
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= StIdle;
      r_count <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_count <= w_count_d;
      if (bus.i_start) begin
        r_err <= 1'b0;
      end else if (r_s1_valid && !r_s1_legal) begin
        r_err <= 1'b1;
      end
    end
  end

  // Stage 1: capture the bundle together with its legality verdict.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_s1_valid  <= 1'b0;
      r_s1_legal  <= 1'b0;
      r_s1_fmt    <= '0;
      r_s1_opcode <= '0;
      r_s1_funct3 <= '0;
      r_s1_funct7 <= '0;
      r_s1_rd     <= '0;
      r_s1_rs1    <= '0;
      r_s1_rs2    <= '0;
      r_s1_imm    <= '0;
    end else begin
      r_s1_valid <= w_accept & ~bus.i_start;
      if (w_accept) begin
        r_s1_legal  <= w_legal;
        r_s1_fmt    <= bus.i_fmt;
        r_s1_opcode <= bus.i_opcode;
        r_s1_funct3 <= bus.i_funct3;
        r_s1_funct7 <= bus.i_funct7;
        r_s1_rd     <= bus.i_rd;
        r_s1_rs1    <= bus.i_rs1;
        r_s1_rs2    <= bus.i_rs2;
        r_s1_imm    <= bus.i_imm;
      end
    end
  end

  // Stage 2: the registered word drives the IMEM write bus for exactly one cycle.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_s2_valid <= 1'b0;
      r_wdata    <= '0;
      r_addr     <= BASE_ADDR;
    end else if (bus.i_start) begin
      r_s2_valid <= 1'b0;
      r_addr     <= BASE_ADDR;
    end else begin
      r_s2_valid <= w_s2_load;
      if (w_s2_load) begin
        r_wdata <= w_enc;
        r_addr  <= w_addr_next;
      end
    end
  end

  assign bus.o_in_ready  = w_in_ready;
  assign bus.o_mem_we    = r_s2_valid;
  assign bus.o_mem_addr  = r_addr;
  assign bus.o_mem_wdata = r_wdata;
  assign bus.o_count     = r_count;
  assign bus.o_full      = (r_count == CapVal);
  assign bus.o_err       = r_err;
  assign bus.o_busy      = (r_state != StIdle) || r_s1_valid || r_s2_valid;

endmodule
